// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented pipelined adder/subtractor with valid/ready flow control
// Optional ovf/zero flag outputs are built when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int STAGES = WIDTH / SEG;

    logic advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operands shrink by one segment per stage while the finished sum grows by one.
        localparam int RW = WIDTH - k * SEG;

        logic [RW-1:0]          a_src;
        logic [RW-1:0]          b_src;
        logic                   c_src;
        logic                   v_src;
        logic [SEG:0]           seg_sum;
        logic [(k+1)*SEG-1:0]   s_next;
        logic [(k+1)*SEG-1:0]   s_q;
        logic                   c_q;
        logic                   v_q;

        assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, c_src};

        if (k == 0) begin : g_head
            assign a_src  = in1;
            assign b_src  = op_sub ? ~in2 : in2;
            assign c_src  = op_sub | cin;
            assign v_src  = in_valid;
            assign s_next = seg_sum[SEG-1:0];
        end else begin : g_body
            assign a_src  = g_stage[k-1].g_fwd.a_q;
            assign b_src  = g_stage[k-1].g_fwd.b_q;
            assign c_src  = g_stage[k-1].c_q;
            assign v_src  = g_stage[k-1].v_q;
            assign s_next = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_next;
                c_q <= seg_sum[SEG];
                v_q <= v_src;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-SEG-1:0] a_q;
            logic [RW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[RW-1:SEG];
                    b_q <= b_src[RW-1:SEG];
                end
            end
        end

`ifdef PIPE_ADDER_FLAGS_EN
        if (k == STAGES - 1) begin : g_flags
            logic ovf_q;
            logic zero_q;

            // Same-sign operands producing an opposite-sign sum is carry-in xor carry-out at the MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= (a_src[RW-1] == b_src[RW-1]) && (s_next[WIDTH-1] != a_src[RW-1]);
                    zero_q <= ~|s_next;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign out       = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};
    assign advance   = out_ready || !out_valid;
    assign in_ready  = advance;

`ifdef PIPE_ADDER_FLAGS_EN
    assign ovf  = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero = g_stage[STAGES-1].g_flags.zero_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder (64/16 pipelined and 32/32 single-stage)
module tb_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op_sub, cin, out_valid, out_ready;
    logic [63:0] in1, in2;
    logic [64:0] out;
    logic        n_in_valid, n_in_ready, n_op_sub, n_cin, n_out_valid, n_out_ready;
    logic [31:0] n_in1, n_in2;
    logic [32:0] n_out;
`ifdef PIPE_ADDER_FLAGS_EN
    logic        ovf, zero, n_ovf, n_zero;
    logic        held_ovf, held_zero;
`endif

    int          total = 0;
    int          bad = 0;
    logic [64:0] exp_q[$];
    logic        exp_ovf_q[$];
    logic        exp_zero_q[$];
    bit          rand_mode = 0;
    bit          held_valid = 0;
    logic [64:0] held_out;
    logic [64:0] e;
    logic        eo, ez;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(64), .SEG(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .cin(cin), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef PIPE_ADDER_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    pipe_adder #(.WIDTH(32), .SEG(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .op_sub(n_op_sub), .cin(n_cin), .in1(n_in1), .in2(n_in2),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out(n_out)
`ifdef PIPE_ADDER_FLAGS_EN
        , .ovf(n_ovf), .zero(n_zero)
`endif
    );

    function automatic logic [64:0] ref_out(input logic sub, input logic c,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [64:0] r;
        if (sub) r = {(a >= b), a - b};
        else     r = {1'b0, a} + {1'b0, b} + {64'd0, c};
        return r;
    endfunction

    function automatic logic ref_ovf(input logic sub, input logic c,
                                     input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] r;
        if (sub) r = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        else     r = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, c});
        return r[65:63] != {3{r[63]}};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held_valid = 0;
        end else begin
            total++;
            assert (in_ready === (out_ready || !out_valid))
            else begin bad++; $error("FAIL in_ready got=%b want=%b", in_ready, out_ready || !out_valid); end
            if (held_valid) begin
                total++;
                assert (out_valid === 1'b1 && out === held_out)
                else begin bad++; $error("FAIL stall_hold got=%b/%h want=1/%h", out_valid, out, held_out); end
`ifdef PIPE_ADDER_FLAGS_EN
                total++;
                assert (ovf === held_ovf && zero === held_zero)
                else begin bad++; $error("FAIL stall_flags got=%b%b want=%b%b", ovf, zero, held_ovf, held_zero); end
`endif
            end
            held_valid = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_out   = out;
`ifdef PIPE_ADDER_FLAGS_EN
            held_ovf   = ovf;
            held_zero  = zero;
`endif
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                assert (exp_q.size() != 0)
                else begin bad++; $error("FAIL unexpected_result got=%h want=none", out); end
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    ez = exp_zero_q.pop_front();
                    total++;
                    assert (out === e)
                    else begin bad++; $error("FAIL result got=%h want=%h", out, e); end
`ifdef PIPE_ADDER_FLAGS_EN
                    total++;
                    assert (ovf === eo && zero === ez)
                    else begin bad++; $error("FAIL flags ovf/zero got=%b%b want=%b%b", ovf, zero, eo, ez); end
`endif
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic sub, input logic c, input logic [63:0] a,
                        input logic [63:0] b, input logic [64:0] want, input logic want_ovf);
        bit took = 0;
        in_valid = 1'b1; op_sub = sub; cin = c; in1 = a; in2 = b;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        total++;
        assert (took) else begin bad++; $error("FAIL accept_timeout got=0 want=1"); end
        if (took) begin
            exp_q.push_back(want);
            exp_ovf_q.push_back(want_ovf);
            exp_zero_q.push_back(want[63:0] == 64'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            op_sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_latency(input int want);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (out_valid === 1'b1);
        end
        total++;
        assert (seen && n == want) else begin bad++; $error("FAIL latency got=%0d want=%0d", n, want); end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        total++;
        assert (exp_q.size() == 0) else begin bad++; $error("FAIL drain got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s, c;
        logic [63:0] a, b;
        bit          seen;

        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0; op_sub = 1'b0; cin = 1'b0;
        in1 = '0; in2 = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_op_sub = 1'b0; n_cin = 1'b0; n_in1 = '0; n_in2 = '0;
        #2;
        total++;
        assert (out_valid === 1'b0 && in_ready === 1'b1 && out === 65'd0)
        else begin bad++; $error("FAIL reset_state got=%b/%b/%h want=0/1/0", out_valid, in_ready, out); end
        total++;
        assert (n_out_valid === 1'b0 && n_out === 33'd0)
        else begin bad++; $error("FAIL reset_narrow got=%b/%h want=0/0", n_out_valid, n_out); end
`ifdef PIPE_ADDER_FLAGS_EN
        total++;
        assert (ovf === 1'b0 && zero === 1'b0)
        else begin bad++; $error("FAIL reset_flags got=%b%b want=00", ovf, zero); end
`endif
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst_n = 1'b1;

        send(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000, 1'b0);
        check_latency(4);
        idle(6);
        send(1'b1, 1'b0, 64'd5, 64'd7, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
        send(1'b1, 1'b1, 64'd7, 64'd5, 65'h1_0000_0000_0000_0002, 1'b0);
        send(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, {1'b0, 64'h8000_0000_0000_0000}, 1'b1);
        send(1'b0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 64'd0, {1'b0, 64'h0001_0000_0000_0000}, 1'b0);
        send(1'b1, 1'b0, 64'd0, 64'd0, 65'h1_0000_0000_0000_0000, 1'b0);
        drain();

        rand_mode = 1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (i % 10 == 0) b = a;
            send(s, c, a, b, ref_out(s, c, a, b), ref_ovf(s, c, a, b));
        end
        rand_mode = 0;
        drain();

        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 64'(i), 64'd1, 65'(i + 1), 1'b0);
        total++;
        assert (out_valid === 1'b1) else begin bad++; $error("FAIL prefill got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        assert (out_valid === 1'b0 && in_ready === 1'b1 && out === 65'd0)
        else begin bad++; $error("FAIL midrun_reset got=%b/%b/%h want=0/1/0", out_valid, in_ready, out); end
        exp_q.delete(); exp_ovf_q.delete(); exp_zero_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1;
        end
        total++;
        assert (!seen) else begin bad++; $error("FAIL stale_after_reset got=1 want=0"); end
        @(posedge clk);
        #1;
        send(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, {1'b0, 64'h2222_2222_2222_2212}, 1'b0);
        check_latency(4);
        drain();

        n_in1 = 32'hFFFF_FFFF; n_in2 = 32'd0; n_cin = 1'b1; n_op_sub = 1'b0; n_in_valid = 1'b1;
        @(negedge clk);
        total++;
        assert (n_in_ready === 1'b1 && n_out_valid === 1'b0)
        else begin bad++; $error("FAIL narrow_pre got=%b/%b want=1/0", n_in_ready, n_out_valid); end
        @(posedge clk);
        #1;
        n_in1 = 32'd0; n_in2 = 32'd1; n_cin = 1'b0; n_op_sub = 1'b1;
        @(negedge clk);
        total++;
        assert (n_out_valid === 1'b1 && n_out === 33'h1_0000_0000)
        else begin bad++; $error("FAIL narrow_add got=%b/%h want=1/100000000", n_out_valid, n_out); end
`ifdef PIPE_ADDER_FLAGS_EN
        total++;
        assert (n_ovf === 1'b0 && n_zero === 1'b1)
        else begin bad++; $error("FAIL narrow_add_flags got=%b%b want=01", n_ovf, n_zero); end
`endif
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        @(negedge clk);
        total++;
        assert (n_out_valid === 1'b1 && n_out === {1'b0, 32'hFFFF_FFFF})
        else begin bad++; $error("FAIL narrow_sub got=%b/%h want=1/0ffffffff", n_out_valid, n_out); end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        assert (n_out_valid === 1'b0)
        else begin bad++; $error("FAIL narrow_bubble got=%b want=0", n_out_valid); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
